window_generator_3x3: RTL and testbench
=======================================

Name: window_generator_3x3

Overview:
- Raster-scan pixel streamer that produces the 3x3 neighbourhoods consumed by the smoothening block.
- Accepts one pixel per handshake and keeps two line buffers plus a 3x3 shift window.
- Emits one full 3x3 window for every interior pixel position ("valid" border mode), so the output frame is (IMG_W-2) x (IMG_H-2).
- Sits between the pixel source (memory/camera reader) and the smoothening filter.

Parameters:
- DW, 12, pixel bit width.
- IMG_W, 640, pixels per line (>=3).
- IMG_H, 480, lines per frame (>=3).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- sof  in  1  synchronous start-of-frame; accepted only together with an in_valid&in_ready handshake, and marks that pixel as (0,0).
- in_pixel  in  DW  input pixel, raster order.
- in_valid  in  1  in_pixel valid.
- in_ready  out  1  block can accept in_pixel this cycle.
- win  out  9*DW  window; slot j occupies bits [j*DW +: DW]; j = 3*r + c, r/c = 0..2; slot 0 is top-left (oldest line, oldest column); slot 8 is the newest pixel.
- win_valid  out  1  win holds a valid window.
- win_ready  in  1  consumer accepts win.
- win_row  out  log2(IMG_H)  output-frame row of win (0..IMG_H-3).
- win_col  out  log2(IMG_W)  output-frame column of win (0..IMG_W-3).
- frame_done  out  1  one-cycle pulse after the last window of the frame is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - in_ready=0, win_valid=0, win=0, win_row=0, win_col=0, frame_done=0.
  - Counters and state are cleared.
  - Line-buffer contents are don't-care.
- State machine: IDLE, FILL, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Pixels arriving without sof are dropped.
  - A handshake with sof=1 stores the pixel as (0,0) and moves to FILL.
- FILL (rows 0..1):
  - in_ready=1; no windows are emitted.
  - On the handshake of pixel (1, IMG_W-1), move to RUN.
- RUN:
  - in_ready = ~win_valid | win_ready (single output register, full throughput).
  - Accepting pixel (r,c) with r>=2 and c>=2 loads win the next cycle and sets win_valid=1, win_row=r-2, win_col=c-2.
  - Accepting a pixel with c<2 shifts it in without producing a window; any prior window is cleared by the handshake as normal.
- Window contents for newest pixel (r,c): slot 3*i+k = pixel(r-2+i, c-2+k).
- Latency: 1 cycle from the input handshake to win_valid.
- Line wrap:
  - The column counter wraps IMG_W-1 -> 0 and increments the row.
  - The shift window never mixes pixels from two different lines in one emitted window.
- win_valid handshake:
  - win_valid stays high and win/win_row/win_col stay stable until win_ready=1.
  - A simultaneous accept and new-window load in the same cycle is legal; the new window replaces the old one.
- Leaving RUN:
  - After the handshake of pixel (IMG_H-1, IMG_W-1), in_ready=0 and the state moves to DONE.
- DONE:
  - Waits for the last window to be accepted.
  - Then pulses frame_done for exactly 1 cycle and returns to IDLE.
- sof in FILL or RUN:
  - Aborts the frame.
  - Any pending window is discarded (win_valid=0 next cycle).
  - The sof pixel becomes (0,0) and the state becomes FILL.
  - frame_done is not pulsed.
- Line buffers:
  - Two IMG_W x DW single-port-per-cycle RAM/register arrays.
  - Read and write use the same column address each handshake.
  - Pixel data is not modified or rounded.
- Reset asserted mid-frame: immediate return to the reset values listed above; no partial window is ever presented.

Test Plan:
- Basic frame: IMG_W=4, IMG_H=4, pixel(r,c)=16r+c, win_ready=1, continuous input.
  - Exactly 4 windows; first window slots = {0,1,2,16,17,18,32,33,34}, win_row=0, win_col=0.
  - Last window = {17,18,19,33,34,35,49,50,51}.
  - frame_done pulses once, 1 cycle after the last accept.
- Backpressure: same frame, win_ready toggling 1,0,0,1...
  - win is stable while stalled; in_ready=0 whenever win_valid=1 and win_ready=0.
  - No window is lost or duplicated (still 4, same values).
- Line wrap: IMG_W=5, IMG_H=3, pixel = 10r+c.
  - Windows have win_col 0,1,2 and the 3rd = {2,3,4,12,13,14,22,23,24}.
  - No window is emitted for c<2.
- Missing and mid-frame sof:
  - Pixels before the first sof are dropped; no output.
  - A sof at pixel 7 of a running frame restarts it; the next first window is built from the new (0,0) pixel; no frame_done for the aborted frame.
- Reset mid-frame: assert reset=0 asynchronously in RUN.
  - win_valid=0 and in_ready=0 immediately.
  - After release, a full frame reproduces the basic-frame results.
- Value extremes: DW=12, all pixels 4095, then all 0.
  - All slots are 4095 (then 0) with no truncation.

Source files
------------

// File: rtl/window_generator_3x3_if.sv
// Pixel-stream and window-stream bundle for window_generator_3x3.
//   sof/in_pixel/in_valid -> in_ready : raster-order pixel input handshake
//   win/win_row/win_col/win_valid -> win_ready : 3x3 window output handshake
//   frame_done : one-cycle pulse after the last window of a frame is taken
// slave  = the window generator, master = pixel source plus window consumer.
interface window_generator_3x3_if #(
  parameter int unsigned DW    = 12,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) ();
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic            sof;
  logic [DW-1:0]   in_pixel;
  logic            in_valid;
  logic            in_ready;
  logic [9*DW-1:0] win;
  logic            win_valid;
  logic            win_ready;
  logic [RW-1:0]   win_row;
  logic [CW-1:0]   win_col;
  logic            frame_done;

  modport master (
    output sof, in_pixel, in_valid, win_ready,
    input  in_ready, win, win_valid, win_row, win_col, frame_done
  );

  modport slave (
    input  sof, in_pixel, in_valid, win_ready,
    output in_ready, win, win_valid, win_row, win_col, frame_done
  );
endinterface

// File: rtl/window_generator_3x3.sv
// Raster-scan 3x3 window generator ("valid" border mode).
// Two line buffers hold the previous two lines; a two-column shift window plus
// the column being read this handshake forms each 3x3 neighbourhood.
// Ports: clk, reset (async, active-low), bus (slave side of window_generator_3x3_if).
// Window slot 3*i+k = pixel(r-2+i, c-2+k) for newest pixel (r,c).
module window_generator_3x3 #(
  parameter int unsigned DW    = 12,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic                 clk,
  input  logic                 reset,
  window_generator_3x3_if.slave bus
);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned WW = 9 * DW;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               active_q;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [2:0][DW-1:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic [WW-1:0]      win_q, win_d;
  logic               win_valid_q, win_valid_d;
  logic [RW-1:0]      win_row_q, win_row_d;
  logic [CW-1:0]      win_col_q, win_col_d;
  logic               frame_done_q, frame_done_d;
  logic [DW-1:0]      lb0_q [IMG_W];
  logic [DW-1:0]      lb1_q [IMG_W];

  logic               in_ready_c, take_c, emit_c;
  logic [RW-1:0]      pos_r_c;
  logic [CW-1:0]      pos_c_c;
  logic [2:0][DW-1:0] new_col_c;

  // Next-state, window assembly and handshake control.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    sh1_d        = sh1_q;
    sh2_d        = sh2_q;
    win_d        = win_q;
    win_valid_d  = win_valid_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    frame_done_d = 1'b0;
    in_ready_c   = 1'b0;

    // active_q keeps in_ready low while reset is held and for the first edge after.
    case (state_q)
      S_IDLE, S_FILL: in_ready_c = active_q;
      S_RUN:          in_ready_c = active_q & (~win_valid_q | bus.win_ready);
      default:        in_ready_c = 1'b0;
    endcase

    // In IDLE only a sof pixel is taken; others are handshaken and dropped.
    take_c  = bus.in_valid & in_ready_c & ((state_q != S_IDLE) | bus.sof);
    pos_r_c = bus.sof ? '0 : row_q;
    pos_c_c = bus.sof ? '0 : col_q;
    // Column entering the window: [0]=two lines up, [1]=one line up, [2]=new pixel.
    new_col_c = {bus.in_pixel, lb1_q[pos_c_c], lb0_q[pos_c_c]};
    emit_c    = take_c & (pos_r_c >= RW'(2)) & (pos_c_c >= CW'(2));

    if (win_valid_q & bus.win_ready) win_valid_d = 1'b0;

    if (take_c) begin
      sh2_d       = sh1_q;
      sh1_d       = new_col_c;
      win_valid_d = emit_c;
      if (emit_c) begin
        for (int i = 0; i < 3; i++) begin
          win_d[(3*i)*DW   +: DW] = sh2_q[i];
          win_d[(3*i+1)*DW +: DW] = sh1_q[i];
          win_d[(3*i+2)*DW +: DW] = new_col_c[i];
        end
        win_row_d = pos_r_c - RW'(2);
        win_col_d = pos_c_c - CW'(2);
      end
      if (pos_c_c == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = pos_r_c + RW'(1);
      end else begin
        col_d = pos_c_c + CW'(1);
        row_d = pos_r_c;
      end
    end

    case (state_q)
      S_IDLE: if (take_c) state_d = S_FILL;
      S_FILL, S_RUN: begin
        if (take_c) begin
          if (bus.sof) begin
            state_d = S_FILL;
          end else if (pos_r_c == RW'(1) && pos_c_c == CW'(IMG_W - 1)) begin
            state_d = S_RUN;
          end else if (pos_r_c == RW'(IMG_H - 1) && pos_c_c == CW'(IMG_W - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (~win_valid_q | bus.win_ready) begin
          frame_done_d = 1'b1;
          win_valid_d  = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      active_q     <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      sh1_q        <= '0;
      sh2_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= 1'b1;
      row_q        <= row_d;
      col_q        <= col_d;
      sh1_q        <= sh1_d;
      sh2_q        <= sh2_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers: lb1 holds the previous line, lb0 the one before; contents need no reset.
  always_ff @(posedge clk) begin
    if (take_c) begin
      lb0_q[pos_c_c] <= new_col_c[1];
      lb1_q[pos_c_c] <= bus.in_pixel;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.win        = win_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_window_generator_3x3.sv
// Directed self-checking bench for window_generator_3x3: a 4x4 instance and a 5x3 instance.
module tb_window_generator_3x3;
  localparam int unsigned DW = 12;
  localparam int unsigned WW = 9 * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_generator_3x3_if #(.DW(DW), .IMG_W(4), .IMG_H(4)) bus_a ();
  window_generator_3x3_if #(.DW(DW), .IMG_W(5), .IMG_H(3)) bus_b ();

  window_generator_3x3 #(.DW(DW), .IMG_W(4), .IMG_H(4)) u_a (
    .clk(clk), .reset(rst_n), .bus(bus_a.slave)
  );
  window_generator_3x3 #(.DW(DW), .IMG_W(5), .IMG_H(3)) u_b (
    .clk(clk), .reset(rst_n), .bus(bus_b.slave)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Hand-computed windows: 4x4 frame pixel=16r+c, 5x3 frame pixel=10r+c.
  int tbl_a [4][9] = '{'{0, 1, 2, 16, 17, 18, 32, 33, 34},
                       '{1, 2, 3, 17, 18, 19, 33, 34, 35},
                       '{16, 17, 18, 32, 33, 34, 48, 49, 50},
                       '{17, 18, 19, 33, 34, 35, 49, 50, 51}};
  int tbl_b [3][9] = '{'{0, 1, 2, 10, 11, 12, 20, 21, 22},
                       '{1, 2, 3, 11, 12, 13, 21, 22, 23},
                       '{2, 3, 4, 12, 13, 14, 22, 23, 24}};

  int pix_q [$];
  bit sof_q [$];

  logic [WW-1:0] qa_w [$];
  int qa_r [$], qa_c [$];
  logic [WW-1:0] qb_w [$];
  int qb_r [$], qb_c [$];
  int fd_a = 0, fd_b = 0, fd_cyc_a = 0, acc_cyc_a = 0, cyc = 0;

  // Record every accepted window and every frame_done pulse.
  always @(posedge clk) begin
    cyc++;
    if (bus_a.win_valid && bus_a.win_ready) begin
      qa_w.push_back(bus_a.win);
      qa_r.push_back(int'(bus_a.win_row));
      qa_c.push_back(int'(bus_a.win_col));
      acc_cyc_a = cyc;
    end
    if (bus_a.frame_done) begin
      fd_a++;
      fd_cyc_a = cyc;
    end
    if (bus_b.win_valid && bus_b.win_ready) begin
      qb_w.push_back(bus_b.win);
      qb_r.push_back(int'(bus_b.win_row));
      qb_c.push_back(int'(bus_b.win_col));
    end
    if (bus_b.frame_done) fd_b++;
  end

  function automatic logic [WW-1:0] exp_win_a(input int k, input int off);
    logic [WW-1:0] v;
    v = '0;
    for (int s = 0; s < 9; s++) v[s*DW +: DW] = DW'(tbl_a[k][s] + off);
    return v;
  endfunction

  function automatic logic [WW-1:0] exp_win_b(input int k);
    logic [WW-1:0] v;
    v = '0;
    for (int s = 0; s < 9; s++) v[s*DW +: DW] = DW'(tbl_b[k][s]);
    return v;
  endfunction

  task automatic clear_mon;
    qa_w.delete(); qa_r.delete(); qa_c.delete();
    qb_w.delete(); qb_r.delete(); qb_c.delete();
    fd_a = 0; fd_b = 0; fd_cyc_a = 0; acc_cyc_a = 0;
    pix_q.delete(); sof_q.delete();
  endtask

  task automatic add_frame_a(input int off, input int fixed);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        pix_q.push_back(fixed >= 0 ? fixed : 16*r + c + off);
        sof_q.push_back(r == 0 && c == 0);
      end
  endtask

  // Stream pix_q into instance A; with bp, win_ready follows 1,0,0,1,0,0...
  task automatic drive_a(input bit bp);
    int i, n, tail;
    bit stalled, hs;
    logic [WW-1:0] held;
    i = 0; n = 0; tail = 0; stalled = 0; held = '0;
    while (tail < 10 && n < 400) begin
      @(negedge clk);
      bus_a.win_ready = bp ? (n % 3 == 0) : 1'b1;
      if (i < pix_q.size()) begin
        bus_a.in_valid = 1'b1;
        bus_a.in_pixel = DW'(pix_q[i]);
        bus_a.sof      = sof_q[i];
      end else begin
        bus_a.in_valid = 1'b0;
        bus_a.sof      = 1'b0;
      end
      #1;
      if (stalled) begin
        tests_run++;
        if (bus_a.win_valid !== 1'b1 || bus_a.win !== held) begin
          tests_failed++;
          $display("FAIL stall_hold: win_valid=%b win=%h, required 1 %h", bus_a.win_valid, bus_a.win, held);
        end
      end
      stalled = bus_a.win_valid && !bus_a.win_ready;
      if (stalled) begin
        held = bus_a.win;
        tests_run++;
        if (bus_a.in_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL stall_in_ready: in_ready=%b, required 0", bus_a.in_ready);
        end
      end
      hs = bus_a.in_valid && bus_a.in_ready;
      @(posedge clk);
      if (hs) i++;
      if (i >= pix_q.size()) tail++;
      n++;
    end
    if (i < pix_q.size()) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drive_a_timeout: sent %0d, required %0d pixels", i, pix_q.size());
    end
    @(negedge clk);
    bus_a.in_valid = 1'b0; bus_a.sof = 1'b0; bus_a.win_ready = 1'b1;
  endtask

  task automatic drive_b;
    int i, n, tail;
    bit hs;
    i = 0; n = 0; tail = 0;
    while (tail < 10 && n < 400) begin
      @(negedge clk);
      bus_b.win_ready = 1'b1;
      bus_b.in_valid  = (i < pix_q.size());
      bus_b.in_pixel  = (i < pix_q.size()) ? DW'(pix_q[i]) : '0;
      bus_b.sof       = (i < pix_q.size()) ? sof_q[i] : 1'b0;
      #1;
      hs = bus_b.in_valid && bus_b.in_ready;
      @(posedge clk);
      if (hs) i++;
      if (i >= pix_q.size()) tail++;
      n++;
    end
    if (i < pix_q.size()) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drive_b_timeout: sent %0d, required %0d pixels", i, pix_q.size());
    end
    @(negedge clk);
    bus_b.in_valid = 1'b0; bus_b.sof = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    tests_run += 6;
    if (bus_a.in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b, required 0", bus_a.in_ready); end
    if (bus_a.win_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_win_valid: got %b, required 0", bus_a.win_valid); end
    if (bus_a.win !== '0) begin tests_failed++; $display("FAIL rst_win: got %h, required 0", bus_a.win); end
    if (bus_a.win_row !== '0 || bus_a.win_col !== '0) begin tests_failed++; $display("FAIL rst_row_col: got %0d/%0d, required 0/0", bus_a.win_row, bus_a.win_col); end
    if (bus_a.frame_done !== 1'b0) begin tests_failed++; $display("FAIL rst_frame_done: got %b, required 0", bus_a.frame_done); end
    if (bus_b.in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_b_in_ready: got %b, required 0", bus_b.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if (bus_a.in_ready !== 1'b1) begin tests_failed++; $display("FAIL idle_in_ready: got %b, required 1", bus_a.in_ready); end
  endtask

  task automatic test_basic_frame(input bit bp, input int off);
    logic [WW-1:0] g;
    int gr, gc;
    tests_run++;
    if (qa_w.size() != 4) begin tests_failed++; $display("FAIL frame_count(bp=%0d): got %0d windows, required 4", bp, qa_w.size()); end
    for (int k = 0; k < 4; k++) begin
      g = '0; gr = -1; gc = -1;
      if (k < qa_w.size()) begin g = qa_w[k]; gr = qa_r[k]; gc = qa_c[k]; end
      tests_run++;
      if (g !== exp_win_a(k, off) || gr != k / 2 || gc != k % 2) begin
        tests_failed++;
        $display("FAIL frame_win%0d(bp=%0d): got %h r%0d c%0d, required %h r%0d c%0d",
                 k, bp, g, gr, gc, exp_win_a(k, off), k / 2, k % 2);
      end
    end
    tests_run += 2;
    if (fd_a != 1) begin tests_failed++; $display("FAIL frame_done_count(bp=%0d): got %0d, required 1", bp, fd_a); end
    if (fd_cyc_a != acc_cyc_a + 1) begin tests_failed++; $display("FAIL frame_done_timing(bp=%0d): got cycle %0d, required %0d", bp, fd_cyc_a, acc_cyc_a + 1); end
  endtask

  task automatic test_basic;
    clear_mon();
    add_frame_a(0, -1);
    drive_a(1'b0);
    test_basic_frame(1'b0, 0);
  endtask

  task automatic test_backpressure;
    clear_mon();
    add_frame_a(0, -1);
    drive_a(1'b1);
    test_basic_frame(1'b1, 0);
  endtask

  task automatic test_line_wrap;
    logic [WW-1:0] g;
    int gr, gc;
    clear_mon();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) begin
        pix_q.push_back(10*r + c);
        sof_q.push_back(r == 0 && c == 0);
      end
    drive_b();
    tests_run += 2;
    if (qb_w.size() != 3) begin tests_failed++; $display("FAIL wrap_count: got %0d windows, required 3", qb_w.size()); end
    if (fd_b != 1) begin tests_failed++; $display("FAIL wrap_frame_done: got %0d, required 1", fd_b); end
    for (int k = 0; k < 3; k++) begin
      g = '0; gr = -1; gc = -1;
      if (k < qb_w.size()) begin g = qb_w[k]; gr = qb_r[k]; gc = qb_c[k]; end
      tests_run++;
      if (g !== exp_win_b(k) || gr != 0 || gc != k) begin
        tests_failed++;
        $display("FAIL wrap_win%0d: got %h r%0d c%0d, required %h r0 c%0d", k, g, gr, gc, exp_win_b(k), k);
      end
    end
  endtask

  task automatic test_missing_sof;
    clear_mon();
    for (int p = 0; p < 6; p++) begin
      pix_q.push_back(100 + p);
      sof_q.push_back(1'b0);
    end
    drive_a(1'b0);
    #1;
    tests_run += 3;
    if (qa_w.size() != 0) begin tests_failed++; $display("FAIL nosof_windows: got %0d, required 0", qa_w.size()); end
    if (fd_a != 0) begin tests_failed++; $display("FAIL nosof_frame_done: got %0d, required 0", fd_a); end
    if (bus_a.in_ready !== 1'b1) begin tests_failed++; $display("FAIL nosof_in_ready: got %b, required 1", bus_a.in_ready); end
  endtask

  task automatic test_mid_sof;
    clear_mon();
    for (int p = 0; p < 7; p++) begin
      pix_q.push_back(16*(p / 4) + p % 4);
      sof_q.push_back(p == 0);
    end
    add_frame_a(200, -1);
    drive_a(1'b0);
    test_basic_frame(1'b0, 200);
  endtask

  task automatic test_reset_mid;
    clear_mon();
    for (int p = 0; p < 11; p++) begin
      @(negedge clk);
      bus_a.win_ready = 1'b1;
      bus_a.in_valid  = 1'b1;
      bus_a.in_pixel  = DW'(16*(p / 4) + p % 4);
      bus_a.sof       = (p == 0);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus_a.win_valid !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_win_valid: got %b, required 1", bus_a.win_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run += 3;
    if (bus_a.win_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_win_valid: got %b, required 0", bus_a.win_valid); end
    if (bus_a.in_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_in_ready: got %b, required 0", bus_a.in_ready); end
    if (bus_a.win !== '0) begin tests_failed++; $display("FAIL midrst_win: got %h, required 0", bus_a.win); end
    @(negedge clk);
    bus_a.in_valid = 1'b0; bus_a.sof = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon();
    add_frame_a(0, -1);
    drive_a(1'b0);
    test_basic_frame(1'b0, 0);
  endtask

  task automatic test_extremes;
    clear_mon();
    add_frame_a(0, 4095);
    add_frame_a(0, 0);
    drive_a(1'b0);
    tests_run += 2;
    if (qa_w.size() != 8) begin tests_failed++; $display("FAIL ext_count: got %0d windows, required 8", qa_w.size()); end
    if (fd_a != 2) begin tests_failed++; $display("FAIL ext_frame_done: got %0d, required 2", fd_a); end
    for (int k = 0; k < 8; k++) begin
      logic [WW-1:0] g, e;
      g = 'x;
      if (k < qa_w.size()) g = qa_w[k];
      e = (k < 4) ? {9{12'hfff}} : '0;
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL ext_win%0d: got %h, required %h", k, g, e); end
    end
  endtask

  initial begin
    bus_a.sof = 1'b0; bus_a.in_pixel = '0; bus_a.in_valid = 1'b0; bus_a.win_ready = 1'b1;
    bus_b.sof = 1'b0; bus_b.in_pixel = '0; bus_b.in_valid = 1'b0; bus_b.win_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_line_wrap();
    test_missing_sof();
    test_mid_sof();
    test_reset_mid();
    test_extremes();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion before 500000");
    $fatal(1);
  end
endmodule
